// File: rtl/ctc_timer.sv
// ---------------------------------------------------------------------------
// ctc_timer
// Memory-mapped countdown timer. The CPU loads a 32-bit tick count through
// timerValue and starts/stops it through controlReg. The counter decrements
// once every CLK_PER_TICK clocks and pulses interrupt for one cycle when it
// expires. In periodic mode it reloads and keeps running.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   timerValue  in   32  load bus; nonzero loads the timer, 0 = no load
//   controlReg  in   8   bit0 start, bit1 stop, bit2 periodic, bits7:3 unused
//   interrupt   out  1   registered one-cycle expiry pulse
// ---------------------------------------------------------------------------
module ctc_timer #(
    parameter int unsigned CLK_PER_TICK = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] timerValue,
    input  logic [7:0]  controlReg,
    output logic        interrupt
);

    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] PRESC_LAST = CW'(CLK_PER_TICK - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Architectural state
    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_reload;
    logic [CW-1:0]   r_presc;
    logic            r_periodic;
    logic [1:0]      r_ctl_q;
    logic            r_irq;

    // Next-state values
    state_t          w_state_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   w_reload_nxt;
    logic [CW-1:0]   w_presc_nxt;
    logic            w_periodic_nxt;
    logic            w_irq_nxt;

    // Decoded bus events
    logic            w_load;
    logic            w_start_edge;
    logic            w_stop_edge;
    logic [CW-1:0]   w_count_eff;
    logic            w_unused_ctl;

    assign w_load       = |timerValue;
    assign w_start_edge = controlReg[0] & ~r_ctl_q[0];
    assign w_stop_edge  = controlReg[1] & ~r_ctl_q[1];
    // Count as seen by a start edge: a same-cycle load counts as already done
    assign w_count_eff  = w_load ? timerValue : r_count;
    assign w_unused_ctl = ^controlReg[7:3];

    assign interrupt = r_irq;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_presc    <= '0;
            r_periodic <= 1'b0;
            r_ctl_q    <= 2'b00;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_reload   <= w_reload_nxt;
            r_presc    <= w_presc_nxt;
            r_periodic <= w_periodic_nxt;
            r_ctl_q    <= controlReg[1:0];
            r_irq      <= w_irq_nxt;
        end
    end

    // Next-state logic: load, then stop/start, then prescaled countdown
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_reload_nxt   = r_reload;
        w_presc_nxt    = r_presc;
        w_periodic_nxt = r_periodic;
        w_irq_nxt      = 1'b0;

        if (w_load) begin
            w_count_nxt  = timerValue;
            w_reload_nxt = timerValue;
            w_presc_nxt  = '0;
        end

        if (w_stop_edge) begin
            // Pause: count and prescaler keep their values
            w_state_nxt = ST_IDLE;
        end else if (w_start_edge && (w_count_eff != '0)) begin
            w_state_nxt    = ST_RUN;
            w_presc_nxt    = '0;
            w_periodic_nxt = controlReg[2];
        end else if (!w_load && (r_state == ST_RUN)) begin
            if (r_presc == PRESC_LAST) begin
                w_presc_nxt = '0;
                if (r_count == CW'(1)) begin
                    w_irq_nxt = 1'b1;
                    if (r_periodic) begin
                        w_count_nxt = r_reload;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_count != '0) begin
                    w_count_nxt = r_count - CW'(1);
                end
            end else begin
                w_presc_nxt = r_presc + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ctc_timer.sv
// ---------------------------------------------------------------------------
// tb_ctc_timer
// Directed scenarios plus random bus traffic for ctc_timer (CLK_PER_TICK=4).
// The reference model tracks the timer as "count at base cycle + elapsed
// cycles" and derives expiry times arithmetically.
// ---------------------------------------------------------------------------
module tb_ctc_timer;

    localparam int P = 4;

    logic        clk;
    logic        rst;
    logic [31:0] tv;
    logic [7:0]  cr;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int pulses[$];

    // Reference model state
    longint m_t          = 0;
    longint m_base_cycle = 0;
    longint m_base_count = 0;
    longint m_reload     = 0;
    bit     m_running    = 0;
    bit     m_periodic   = 0;
    bit [1:0] m_q        = 2'b00;
    bit     m_irq        = 0;

    ctc_timer #(.CLK_PER_TICK(P)) dut (
        .clk        (clk),
        .reset      (rst),
        .timerValue (tv),
        .controlReg (cr),
        .interrupt  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected behaviour for the next rising edge given the inputs on the bus
    task automatic model_update(input logic r, input logic [31:0] v, input logic [7:0] c);
        longint cnt_prev;
        longint eff;
        bit ld, se, pe;
        m_t++;
        m_irq = 0;
        if (r) begin
            m_running = 0; m_periodic = 0; m_base_count = 0; m_reload = 0; m_q = 2'b00;
            return;
        end
        ld = (v != 0);
        se = c[0] && !m_q[0];
        pe = c[1] && !m_q[1];
        m_q = c[1:0];
        // Decrements happen at base+P, base+2P, ... after a (re)start or load
        cnt_prev = m_running ? m_base_count - (m_t - 1 - m_base_cycle) / P : m_base_count;
        eff = ld ? longint'(v) : cnt_prev;
        if (ld) m_reload = longint'(v);
        if (pe) begin
            m_running = 0;
            m_base_count = eff;
        end else if (se && eff != 0) begin
            m_running = 1; m_periodic = c[2];
            m_base_count = eff; m_base_cycle = m_t;
        end else if (ld) begin
            m_base_count = eff; m_base_cycle = m_t;
        end else if (m_running && (m_t - m_base_cycle) == m_base_count * P) begin
            m_irq = 1;
            if (m_periodic) begin
                m_base_count = m_reload; m_base_cycle = m_t;
            end else begin
                m_running = 0; m_base_count = 0;
            end
        end
    endtask

    // One clock: drive at negedge, predict, compare at next negedge
    task automatic step(input logic r, input logic [31:0] v, input logic [7:0] c);
        rst = r; tv = v; cr = c;
        model_update(r, v, c);
        @(negedge clk);
        cyc++;
        check("irq", 32'(irq), 32'(m_irq));
        if (irq === 1'b1) pulses.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 8'h00);
    endtask

    function automatic int delta(input int idx, input int base);
        if (idx < pulses.size()) return pulses[idx] - base;
        return -1;
    endfunction

    initial begin
        int c0;
        rst = 1'b1; tv = '0; cr = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd0, 8'h00);
        check("reset_irq", 32'(irq), 32'd0);

        // Idle buses: no interrupt
        pulses.delete();
        idle(100);
        check("idle_pulses", 32'(pulses.size()), 32'd0);

        // One-shot: V=3 -> pulse 3*4+1 cycles after start
        pulses.delete();
        step(1'b0, 32'd3, 8'h00);
        c0 = cyc;
        step(1'b0, 32'd0, 8'h01);
        idle(40);
        check("oneshot_count", 32'(pulses.size()), 32'd1);
        check("oneshot_delay", 32'(delta(0, c0)), 32'd13);

        // Periodic: V=2 -> pulses every 8 cycles
        pulses.delete();
        step(1'b0, 32'd2, 8'h00);
        c0 = cyc;
        step(1'b0, 32'd0, 8'h05);
        idle(40);
        check("periodic_count", 32'(pulses.size()), 32'd5);
        check("periodic_first", 32'(delta(0, c0)), 32'd9);
        for (int i = 1; i < 5; i++)
            check("periodic_gap", 32'(delta(i, c0) - delta(i - 1, c0)), 32'd8);
        step(1'b0, 32'd0, 8'h02);
        idle(20);

        // Pause/resume: load 5, stop 6 cycles in (one tick consumed, 4 left)
        pulses.delete();
        step(1'b0, 32'd5, 8'h00);
        c0 = cyc;
        step(1'b0, 32'd0, 8'h01);
        idle(5);
        step(1'b0, 32'd0, 8'h02);
        idle(50);
        check("paused_pulses", 32'(pulses.size()), 32'd0);
        c0 = cyc;
        step(1'b0, 32'd0, 8'h01);
        idle(30);
        check("resume_count", 32'(pulses.size()), 32'd1);
        // 4 remaining ticks with a fresh prescaler: 4*4+1
        check("resume_delay", 32'(delta(0, c0)), 32'd17);

        // Start held with count==0: ignored
        pulses.delete();
        for (int i = 0; i < 30; i++) step(1'b0, 32'd0, 8'h01);
        idle(1);
        check("zero_start", 32'(pulses.size()), 32'd0);

        // Start and stop together on a running timer: stop wins
        step(1'b0, 32'd4, 8'h00);
        step(1'b0, 32'd0, 8'h01);
        idle(5);
        step(1'b0, 32'd0, 8'h03);
        idle(40);
        check("startstop", 32'(pulses.size()), 32'd0);

        // Reset mid-count, then a fresh load of 1
        step(1'b0, 32'd6, 8'h00);
        step(1'b0, 32'd0, 8'h01);
        idle(10);
        step(1'b1, 32'd0, 8'h00);
        step(1'b1, 32'd0, 8'h00);
        idle(40);
        check("reset_mid", 32'(pulses.size()), 32'd0);
        step(1'b0, 32'd1, 8'h00);
        c0 = cyc;
        step(1'b0, 32'd0, 8'h01);
        idle(10);
        check("after_reset_count", 32'(pulses.size()), 32'd1);
        check("after_reset_delay", 32'(delta(0, c0)), 32'd5);

        // Random bus traffic against the model
        pulses.delete();
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [31:0] v;
            logic [7:0]  c;
            r = ($urandom_range(0, 499) == 0);
            v = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1, 12)) : 32'd0;
            c = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            step(r, v, c);
        end
        check("random_activity", 32'(pulses.size() > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
